pipe_ctrl_unit: RTL and testbench

//  Pipelined main control for the MIPS32 core. Decodes the ID-stage opcode into the control

---
 rtl/pipe_ctrl_unit.sv | 218 +++++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// Pipelined main control: decodes the ID opcode into a control bundle and carries it
// through ID/EX, EX/MEM and MEM/WB, with load-use stall detection and flush bubbles.
module pipe_ctrl_unit #(
  parameter int OPW        = 6,
  parameter int ALUOPW     = 4,
  parameter int REGW       = 5,
  parameter bit EXT_BRANCH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPW-1:0]    opcode,
  input  logic [REGW-1:0]   id_rs,
  input  logic [REGW-1:0]   id_rt,
  input  logic [REGW-1:0]   id_rd,
  input  logic              flush,
  output logic              stall_out,
  output logic              id_illegal,
  output logic              ex_branch,
  output logic [1:0]        ex_jump,
  output logic [ALUOPW-1:0] ex_aluop,
  output logic              ex_alusrc,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic              wb_pc_to_reg,
  output logic [REGW-1:0]   wb_dest
);

  localparam logic [OPW-1:0] OP_R    = OPW'(0);
  localparam logic [OPW-1:0] OP_SW   = OPW'(1);
  localparam logic [OPW-1:0] OP_LW   = OPW'(2);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(3);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(4);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(5);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(7);
  localparam logic [OPW-1:0] OP_BGE  = OPW'(8);
  localparam logic [OPW-1:0] OP_BGT  = OPW'(9);
  localparam logic [OPW-1:0] OP_BLE  = OPW'(10);
  localparam logic [OPW-1:0] OP_BLT  = OPW'(11);
  localparam logic [OPW-1:0] OP_J    = OPW'(12);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(13);
  localparam logic [OPW-1:0] OP_JR   = OPW'(14);

  typedef struct packed {
    logic [1:0]        reg_dest;
    logic              branch;
    logic [1:0]        jump;
    logic              mem_read;
    logic              mem_to_reg;
    logic              mem_write;
    logic              alusrc;
    logic              reg_write;
    logic              pc_to_reg;
    logic [ALUOPW-1:0] aluop;
  } ctrl_t;

  ctrl_t           dec;
  logic            illegal_c;
  logic [REGW-1:0] id_dest;
  logic            id_reg_write;
  logic            uses_rt;
  logic            hazard;
  logic            bubble;

  logic              vld_p0, branch_p0, alusrc_p0, mem_read_p0, mem_write_p0;
  logic              reg_write_p0, mem_to_reg_p0, pc_to_reg_p0;
  logic [1:0]        jump_p0;
  logic [ALUOPW-1:0] aluop_p0;
  logic [REGW-1:0]   dest_p0;

  logic              vld_p1, mem_read_p1, mem_write_p1, reg_write_p1, mem_to_reg_p1, pc_to_reg_p1;
  logic [REGW-1:0]   dest_p1;

  logic              vld_p2, reg_write_p2, mem_to_reg_p2, pc_to_reg_p2;
  logic [REGW-1:0]   dest_p2;

  always_comb begin
    dec       = '0;
    illegal_c = 1'b0;
    case (opcode)
      OP_R: begin
        dec.reg_dest  = 2'b01;
        dec.reg_write = 1'b1;
        dec.aluop     = ALUOPW'(2);
      end
      OP_SW: begin
        dec.mem_write = 1'b1;
        dec.alusrc    = 1'b1;
      end
      OP_LW: begin
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alusrc     = 1'b1;
        dec.reg_write  = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        dec.alusrc    = 1'b1;
        dec.reg_write = 1'b1;
        dec.aluop     = (opcode == OP_ADDI) ? ALUOPW'(0) :
                        (opcode == OP_ANDI) ? ALUOPW'(3) : ALUOPW'(4);
      end
      OP_BEQ, OP_BNE: begin
        dec.branch = 1'b1;
        dec.aluop  = ALUOPW'(opcode - OPW'(1));
      end
      OP_BGE, OP_BGT, OP_BLE, OP_BLT: begin
        if (EXT_BRANCH) begin
          dec.branch = 1'b1;
          dec.aluop  = ALUOPW'(opcode - OPW'(1));
        end else begin
          illegal_c = 1'b1;
        end
      end
      OP_J: begin
        dec.jump   = 2'b01;
        dec.alusrc = 1'b1;
      end
      OP_JAL: begin
        dec.reg_dest  = 2'b10;
        dec.jump      = 2'b01;
        dec.alusrc    = 1'b1;
        dec.reg_write = 1'b1;
        dec.pc_to_reg = 1'b1;
      end
      OP_JR: begin
        dec.jump   = 2'b10;
        dec.alusrc = 1'b1;
      end
      default: illegal_c = 1'b1;
    endcase
  end

  always_comb begin
    case (dec.reg_dest)
      2'b01:   id_dest = id_rd;
      2'b10:   id_dest = '1;
      default: id_dest = id_rt;
    endcase
    id_reg_write = dec.reg_write & (id_dest != '0);
    uses_rt      = (opcode == OP_R) | (opcode == OP_SW) | dec.branch;
    hazard       = vld_p0 & mem_read_p0 & (dest_p0 != '0) &
                   ((dest_p0 == id_rs) | ((dest_p0 == id_rt) & uses_rt));
    bubble       = flush | hazard | illegal_c;
  end

  // A killed instruction cannot cause a stall.
  assign stall_out  = hazard & ~flush;
  assign id_illegal = illegal_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0        <= 1'b0;
      branch_p0     <= 1'b0;
      jump_p0       <= '0;
      aluop_p0      <= '0;
      alusrc_p0     <= 1'b0;
      mem_read_p0   <= 1'b0;
      mem_write_p0  <= 1'b0;
      reg_write_p0  <= 1'b0;
      mem_to_reg_p0 <= 1'b0;
      pc_to_reg_p0  <= 1'b0;
      dest_p0       <= '0;
      vld_p1        <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      reg_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      pc_to_reg_p1  <= 1'b0;
      dest_p1       <= '0;
      vld_p2        <= 1'b0;
      reg_write_p2  <= 1'b0;
      mem_to_reg_p2 <= 1'b0;
      pc_to_reg_p2  <= 1'b0;
      dest_p2       <= '0;
    end else begin
      // ID/EX: flush, stall and illegal opcodes all load a bubble
      vld_p0        <= ~bubble;
      branch_p0     <= bubble ? 1'b0 : dec.branch;
      jump_p0       <= bubble ? 2'b00 : dec.jump;
      aluop_p0      <= bubble ? '0 : dec.aluop;
      alusrc_p0     <= bubble ? 1'b0 : dec.alusrc;
      mem_read_p0   <= bubble ? 1'b0 : dec.mem_read;
      mem_write_p0  <= bubble ? 1'b0 : dec.mem_write;
      reg_write_p0  <= bubble ? 1'b0 : id_reg_write;
      mem_to_reg_p0 <= bubble ? 1'b0 : dec.mem_to_reg;
      pc_to_reg_p0  <= bubble ? 1'b0 : dec.pc_to_reg;
      dest_p0       <= bubble ? '0 : id_dest;
      // EX/MEM
      vld_p1        <= vld_p0;
      mem_read_p1   <= mem_read_p0;
      mem_write_p1  <= mem_write_p0;
      reg_write_p1  <= reg_write_p0;
      mem_to_reg_p1 <= mem_to_reg_p0;
      pc_to_reg_p1  <= pc_to_reg_p0;
      dest_p1       <= dest_p0;
      // MEM/WB
      vld_p2        <= vld_p1;
      reg_write_p2  <= reg_write_p1;
      mem_to_reg_p2 <= mem_to_reg_p1;
      pc_to_reg_p2  <= pc_to_reg_p1;
      dest_p2       <= dest_p1;
    end
  end

  assign ex_branch     = vld_p0 & branch_p0;
  assign ex_jump       = vld_p0 ? jump_p0 : 2'b00;
  assign ex_aluop      = vld_p0 ? aluop_p0 : '0;
  assign ex_alusrc     = vld_p0 & alusrc_p0;
  assign mem_mem_read  = vld_p1 & mem_read_p1;
  assign mem_mem_write = vld_p1 & mem_write_p1;
  assign wb_reg_write  = vld_p2 & reg_write_p2;
  assign wb_mem_to_reg = vld_p2 & mem_to_reg_p2;
  assign wb_pc_to_reg  = vld_p2 & pc_to_reg_p2;
  assign wb_dest       = vld_p2 ? dest_p2 : '0;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: directed scenarios plus a randomized stream checked against a
// table-driven decode model and a history queue giving each stage's instruction by age.
module tb_pipe_ctrl_unit;

  typedef struct packed {
    logic       branch;
    logic [1:0] jump;
    logic [3:0] aluop;
    logic       alusrc;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic [4:0] dest;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic       flush = 1'b1;

  logic       stall_out, id_illegal, ex_branch, ex_alusrc, mem_mem_read, mem_mem_write;
  logic       wb_reg_write, wb_mem_to_reg, wb_pc_to_reg;
  logic [1:0] ex_jump;
  logic [3:0] ex_aluop;
  logic [4:0] wb_dest;

  logic       stall_x, illegal_x, branch_x, alusrc_x, mrd_x, mwr_x, rw_x, m2r_x, p2r_x;
  logic [1:0] jump_x;
  logic [3:0] aluop_x;
  logic [4:0] dest_x;

  int checks = 0;
  int errors = 0;

  ent_t hist[$];
  ent_t nxt;
  logic exp_stall, exp_ill, exp_ill0;

  logic [17:0] reg_out;
  assign reg_out = {ex_branch, ex_jump, ex_aluop, ex_alusrc, mem_mem_read, mem_mem_write,
                    wb_reg_write, wb_mem_to_reg, wb_pc_to_reg, wb_dest};

  pipe_ctrl_unit #(.OPW(6), .ALUOPW(4), .REGW(5), .EXT_BRANCH(1'b1)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .flush(flush), .stall_out(stall_out), .id_illegal(id_illegal), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_pc_to_reg(wb_pc_to_reg), .wb_dest(wb_dest));

  pipe_ctrl_unit #(.OPW(6), .ALUOPW(4), .REGW(5), .EXT_BRANCH(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .flush(flush), .stall_out(stall_x), .id_illegal(illegal_x), .ex_branch(branch_x),
    .ex_jump(jump_x), .ex_aluop(aluop_x), .ex_alusrc(alusrc_x),
    .mem_mem_read(mrd_x), .mem_mem_write(mwr_x), .wb_reg_write(rw_x),
    .wb_mem_to_reg(m2r_x), .wb_pc_to_reg(p2r_x), .wb_dest(dest_x));

  always #5 clk = ~clk;

  // Decode straight from the opcode table; dest 0 never writes.
  function automatic ent_t ref_decode(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd,
                                      input bit ext, output bit ill);
    ent_t e;
    int   sel;
    e = '0; ill = 0; sel = 0;
    case (op)
      6'd0: begin e.aluop = 4'd2; e.reg_write = 1; sel = 1; end
      6'd1: begin e.mem_write = 1; e.alusrc = 1; end
      6'd2: begin e.mem_read = 1; e.mem_to_reg = 1; e.alusrc = 1; e.reg_write = 1; end
      6'd3: begin e.alusrc = 1; e.reg_write = 1; e.aluop = 4'd0; end
      6'd4: begin e.alusrc = 1; e.reg_write = 1; e.aluop = 4'd3; end
      6'd5: begin e.alusrc = 1; e.reg_write = 1; e.aluop = 4'd4; end
      6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11: begin
        if (op >= 6'd8 && !ext) ill = 1;
        else begin e.branch = 1; e.aluop = 4'(op - 6'd1); end
      end
      6'd12: begin e.jump = 2'd1; e.alusrc = 1; end
      6'd13: begin e.jump = 2'd1; e.alusrc = 1; e.reg_write = 1; e.pc_to_reg = 1; sel = 2; end
      6'd14: begin e.jump = 2'd2; e.alusrc = 1; end
      default: ill = 1;
    endcase
    if (ill) return '0;
    e.dest = (sel == 1) ? rd : (sel == 2) ? 5'd31 : rt;
    if (e.dest == 5'd0) e.reg_write = 0;
    return e;
  endfunction

  task automatic apply(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic fl);
    ent_t e1, e0, ex;
    bit   ill1, ill0, uses;
    opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; flush = fl;
    e1 = ref_decode(op, rt, rd, 1'b1, ill1);
    e0 = ref_decode(op, rt, rd, 1'b0, ill0);
    ex = hist[0];
    uses = (op == 6'd0) || (op == 6'd1) || e1.branch;
    exp_stall = ex.mem_read && (ex.dest != 0) && ((ex.dest == rs) || ((ex.dest == rt) && uses)) && !fl;
    exp_ill = ill1;
    exp_ill0 = ill0;
    nxt = (fl || exp_stall || ill1) ? '0 : e1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    hist.push_front(nxt);
    while (hist.size() > 3) void'(hist.pop_back());
  endtask

  task automatic model_reset();
    hist = {ent_t'(0), ent_t'(0), ent_t'(0)};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply(6'd0, 5'd0, 5'd0, 5'd0, 1'b1);
      tick();
    end
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({stall_out, reg_out} !== 19'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", {stall_out, reg_out});
    end
    rst = 1'b0;
    apply(6'd0, 5'd1, 5'd2, 5'd3, 1'b1);
    tick();
    checks++;
    if (reg_out !== 18'd0) begin
      errors++; $display("FAIL reset_first_edge: got %h expected 0", reg_out);
    end
  endtask

  task automatic test_addi();
    idle(3);
    apply(6'd3, 5'd1, 5'd5, 5'd9, 1'b0);
    tick();
    checks++;
    if ({ex_alusrc, ex_aluop} !== 5'b1_0000) begin
      errors++; $display("FAIL addi_ex: got %b expected 10000", {ex_alusrc, ex_aluop});
    end
    idle(2);
    checks++;
    if ({wb_reg_write, wb_dest} !== {1'b1, 5'd5}) begin
      errors++; $display("FAIL addi_wb: got %b/%0d expected 1/5", wb_reg_write, wb_dest);
    end
  endtask

  task automatic test_load_use();
    idle(3);
    apply(6'd2, 5'd1, 5'd7, 5'd0, 1'b0);
    tick();
    apply(6'd0, 5'd7, 5'd2, 5'd9, 1'b0);
    checks++;
    if (stall_out !== 1'b1) begin
      errors++; $display("FAIL load_use_stall: got %b expected 1", stall_out);
    end
    tick();
    checks++;
    if ({ex_branch, ex_jump, ex_aluop, ex_alusrc, mem_mem_read} !== 9'b0_00_0000_0_1) begin
      errors++; $display("FAIL load_use_bubble: got %b expected 000000001",
                         {ex_branch, ex_jump, ex_aluop, ex_alusrc, mem_mem_read});
    end
    apply(6'd0, 5'd7, 5'd2, 5'd9, 1'b0);
    checks++;
    if (stall_out !== 1'b0) begin
      errors++; $display("FAIL load_use_one_cycle: got %b expected 0", stall_out);
    end
    tick();
    checks++;
    if (ex_aluop !== 4'b0010) begin
      errors++; $display("FAIL load_use_rtype_ex: got %b expected 0010", ex_aluop);
    end
    idle(2);
    apply(6'd2, 5'd1, 5'd0, 5'd0, 1'b0);
    tick();
    apply(6'd0, 5'd0, 5'd3, 5'd4, 1'b0);
    checks++;
    if (stall_out !== 1'b0) begin
      errors++; $display("FAIL lw_r0_nostall: got %b expected 0", stall_out);
    end
    tick();
    idle(1);
    checks++;
    if ({wb_reg_write, wb_mem_to_reg} !== 2'b01) begin
      errors++; $display("FAIL lw_r0_wb: got %b expected 01", {wb_reg_write, wb_mem_to_reg});
    end
  endtask

  task automatic test_flush();
    idle(3);
    apply(6'd2, 5'd1, 5'd7, 5'd0, 1'b0);
    tick();
    apply(6'd0, 5'd7, 5'd2, 5'd9, 1'b1);
    checks++;
    if (stall_out !== 1'b0) begin
      errors++; $display("FAIL flush_gates_stall: got %b expected 0", stall_out);
    end
    tick();
    checks++;
    if ({ex_branch, ex_jump, ex_aluop, ex_alusrc} !== 8'd0 || mem_mem_read !== 1'b1) begin
      errors++; $display("FAIL flush_bubble: got ex=%b mem_read=%b expected 0/1",
                         {ex_branch, ex_jump, ex_aluop, ex_alusrc}, mem_mem_read);
    end
  endtask

  task automatic test_jal_jr();
    idle(3);
    apply(6'd13, 5'd1, 5'd2, 5'd3, 1'b0);
    tick();
    checks++;
    if (ex_jump !== 2'b01) begin
      errors++; $display("FAIL jal_ex_jump: got %b expected 01", ex_jump);
    end
    idle(2);
    checks++;
    if ({wb_reg_write, wb_pc_to_reg, wb_dest} !== {2'b11, 5'd31}) begin
      errors++; $display("FAIL jal_wb: got %b expected 1111111", {wb_reg_write, wb_pc_to_reg, wb_dest});
    end
    apply(6'd14, 5'd31, 5'd4, 5'd5, 1'b0);
    tick();
    checks++;
    if (ex_jump !== 2'b10) begin
      errors++; $display("FAIL jr_ex_jump: got %b expected 10", ex_jump);
    end
    idle(2);
    checks++;
    if (wb_reg_write !== 1'b0) begin
      errors++; $display("FAIL jr_wb_reg_write: got %b expected 0", wb_reg_write);
    end
  endtask

  task automatic test_ext_branch();
    idle(3);
    apply(6'd9, 5'd1, 5'd2, 5'd3, 1'b0);
    checks++;
    if ({id_illegal, illegal_x} !== 2'b01) begin
      errors++; $display("FAIL ext_branch_illegal: got ext1=%b ext0=%b expected 0/1", id_illegal, illegal_x);
    end
    tick();
    checks++;
    if ({ex_branch, ex_aluop} !== 5'b1_1000) begin
      errors++; $display("FAIL ext1_bgt_ex: got %b expected 11000", {ex_branch, ex_aluop});
    end
    checks++;
    if ({branch_x, aluop_x, jump_x, alusrc_x} !== 8'd0) begin
      errors++; $display("FAIL ext0_bgt_bubble: got %b expected 0", {branch_x, aluop_x, jump_x, alusrc_x});
    end
    apply(6'h3F, 5'd1, 5'd2, 5'd3, 1'b0);
    checks++;
    if ({id_illegal, illegal_x} !== 2'b11) begin
      errors++; $display("FAIL op3f_illegal: got %b%b expected 11", id_illegal, illegal_x);
    end
    tick();
    checks++;
    if ({ex_branch, ex_jump, ex_aluop, ex_alusrc} !== 8'd0) begin
      errors++; $display("FAIL op3f_bubble: got %b expected 0", {ex_branch, ex_jump, ex_aluop, ex_alusrc});
    end
  endtask

  task automatic test_random();
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    logic       fl;
    logic       held;
    ent_t       ex, mm, wb;
    held = 0; op = 0; rs = 0; rt = 0; rd = 0;
    for (int i = 0; i < 400; i++) begin
      if (!held) begin
        op = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(15, 63)) : 6'($urandom_range(0, 14));
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) rd = 5'd31;
      end
      fl = ($urandom_range(0, 7) == 0);
      apply(op, rs, rt, rd, fl);
      held = exp_stall;
      checks++;
      if ({stall_out, id_illegal, illegal_x} !== {exp_stall, exp_ill, exp_ill0}) begin
        errors++; $display("FAIL rand_comb[%0d]: op=%0h got %b%b%b expected %b%b%b", i, op,
                           stall_out, id_illegal, illegal_x, exp_stall, exp_ill, exp_ill0);
      end
      tick();
      ex = hist[0]; mm = hist[1]; wb = hist[2];
      checks++;
      if ({ex_branch, ex_jump, ex_aluop, ex_alusrc} !== {ex.branch, ex.jump, ex.aluop, ex.alusrc}) begin
        errors++; $display("FAIL rand_ex[%0d]: got %b expected %b", i,
                           {ex_branch, ex_jump, ex_aluop, ex_alusrc}, {ex.branch, ex.jump, ex.aluop, ex.alusrc});
      end
      checks++;
      if ({mem_mem_read, mem_mem_write} !== {mm.mem_read, mm.mem_write}) begin
        errors++; $display("FAIL rand_mem[%0d]: got %b expected %b", i,
                           {mem_mem_read, mem_mem_write}, {mm.mem_read, mm.mem_write});
      end
      checks++;
      if ({wb_reg_write, wb_mem_to_reg, wb_pc_to_reg, wb_dest} !==
          {wb.reg_write, wb.mem_to_reg, wb.pc_to_reg, wb.dest}) begin
        errors++; $display("FAIL rand_wb[%0d]: got %b expected %b", i,
                           {wb_reg_write, wb_mem_to_reg, wb_pc_to_reg, wb_dest},
                           {wb.reg_write, wb.mem_to_reg, wb.pc_to_reg, wb.dest});
      end
    end
  endtask

  task automatic test_reset_midstream();
    idle(3);
    apply(6'd1, 5'd1, 5'd2, 5'd0, 1'b0); tick();
    apply(6'd2, 5'd1, 5'd6, 5'd0, 1'b0); tick();
    apply(6'd0, 5'd2, 5'd3, 5'd4, 1'b0); tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({stall_out, reg_out} !== 19'd0) begin
      errors++; $display("FAIL midstream_async_reset: got %h expected 0", {stall_out, reg_out});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    apply(6'd3, 5'd1, 5'd12, 5'd0, 1'b0);
    tick();
    checks++;
    if ({ex_alusrc, ex_aluop, mem_mem_read, mem_mem_write, wb_reg_write} !== 8'b1_0000_000) begin
      errors++; $display("FAIL post_reset_ex: got %b expected 10000000",
                         {ex_alusrc, ex_aluop, mem_mem_read, mem_mem_write, wb_reg_write});
    end
    idle(2);
    checks++;
    if ({wb_reg_write, wb_dest} !== {1'b1, 5'd12}) begin
      errors++; $display("FAIL post_reset_wb: got %b/%0d expected 1/12", wb_reg_write, wb_dest);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_flush();
    test_jal_jr();
    test_ext_branch();
    test_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
